// File: rtl/sig_pkg.sv
// sig_pkg
//  Shared types and constants for the response signature collector.
//  - state_t   : collector FSM states (IDLE, CAPTURE, HOLD)
//  - DEF_POLY  : default CRC-16/CCITT feedback polynomial (x^16 term implied)
//  - DEF_SEED  : default signature value loaded at window start
//  - crc_step  : one serial CRC shift for the default 16-bit width. It is a
//                software-side reference for scripts and benches; the RTL
//                datapath uses the width-parameterised sig_lfsr_step module.
package sig_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [15:0] DEF_POLY = 16'h1021;
  localparam logic [15:0] DEF_SEED = 16'h0000;

  // Galois-style serial CRC: the incoming bit is XORed with the MSB that is
  // shifting out, and that feedback selects whether the polynomial is applied.
  function automatic logic [15:0] crc_step(input logic [15:0] sig,
                                           input logic        bit_in,
                                           input logic [15:0] poly);
    logic fb;
    fb = sig[15] ^ bit_in;
    return {sig[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
  endfunction

endpackage

// File: rtl/sig_lfsr_step.sv
// sig_lfsr_step
//  Combinational next-state of a serial CRC signature register.
//  Ports:
//    sig       in  SIG_W  current signature
//    bit_in    in  1      sample being compacted this cycle
//    sig_next  out SIG_W  signature after absorbing bit_in
//  Parameters: SIG_W (register width), POLY (feedback taps, x^SIG_W implied).
module sig_lfsr_step #(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(16'h1021)
) (
  input  logic [SIG_W-1:0] sig,
  input  logic             bit_in,
  output logic [SIG_W-1:0] sig_next
);

  logic fb;

  always_comb begin
    fb       = sig[SIG_W-1] ^ bit_in;
    sig_next = {sig[SIG_W-2:0], 1'b0} ^ (fb ? POLY : {SIG_W{1'b0}});
  end

endmodule

// File: rtl/response_signature_collector.sv
// response_signature_collector
//  Samples a circuit-under-test output bit once per clock over a fixed window
//  of WINDOW cycles and compacts it into a serial CRC signature plus a
//  saturating ones count. The result is offered through a valid/ready
//  handshake, one record per window. Capture is bit- and cycle-exact so golden
//  and suspect runs can be compared by signature alone.
//  Ports:
//    CK          in   1      clock, all state on posedge
//    reset       in   1      synchronous active-high reset
//    start       in   1      open a window (honoured only in IDLE)
//    dut_out     in   1      circuit-under-test output, sampled in CAPTURE
//    busy        out  1      high while capturing or holding a record
//    sig_valid   out  1      record valid
//    sig_ready   in   1      logger accepts record
//    signature   out  SIG_W  compacted signature (stable while sig_valid)
//    ones_count  out  CNT_W  count of 1 samples in the window (saturating)
//  All outputs come straight from flops; there is no input-to-output
//  combinational path.
module response_signature_collector
  import sig_pkg::*;
#(
  parameter int               SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED   = SIG_W'(DEF_SEED),
  parameter int               WINDOW = 1000,
  parameter int               CNT_W  = 10
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic             dut_out,
  output logic             busy,
  output logic             sig_valid,
  input  logic             sig_ready,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] ones_count
);

  // Parameter sanity: the sample counter must reach WINDOW-1 and the window
  // must contain at least one sample.
  if (WINDOW < 1 || (64'd1 << CNT_W) < 64'(WINDOW)) begin : g_bad_params
    $error("response_signature_collector: need WINDOW>=1 and 2**CNT_W>=WINDOW");
  end
  if (SIG_W < 4) begin : g_bad_width
    $error("response_signature_collector: SIG_W must be >= 4");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] ONES_MAX = {CNT_W{1'b1}};

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [SIG_W-1:0] sig_next;
  logic             last_sample;

  assign last_sample = (cnt == LAST_CNT);

  sig_lfsr_step #(
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_step (
    .sig      (signature),
    .bit_in   (dut_out),
    .sig_next (sig_next)
  );

  // FSM state register
  always_ff @(posedge CK) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next state. HOLD leaves only on a handshake; a start arriving on the
  // same cycle is dropped because it is only looked at in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)       state_next = CAPTURE;
      CAPTURE: if (last_sample) state_next = HOLD;
      HOLD:    if (sig_ready)   state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Status outputs registered from the next state so they line up exactly
  // with the state register without a decode after the flop.
  always_ff @(posedge CK) begin
    if (reset) begin
      busy      <= 1'b0;
      sig_valid <= 1'b0;
    end else begin
      busy      <= (state_next != IDLE);
      sig_valid <= (state_next == HOLD);
    end
  end

  // Signature, ones count and sample counter. Results are left untouched in
  // HOLD and IDLE, so the last record stays visible until the next start.
  always_ff @(posedge CK) begin
    if (reset) begin
      signature  <= '0;
      ones_count <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            signature  <= SEED;
            ones_count <= '0;
            cnt        <= '0;
          end
        end
        CAPTURE: begin
          signature <= sig_next;
          if (dut_out && (ones_count != ONES_MAX))
            ones_count <= ones_count + 1'b1;
          // Wrap on the last sample so a WINDOW of 2**CNT_W cannot overflow.
          if (last_sample) cnt <= '0;
          else             cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_response_signature_collector.sv
// Bench for response_signature_collector. Two instances share the clock:
// dut_a uses a 4-sample window with a 2-bit ones counter (so saturation is
// reachable), dut_b uses the 1000-sample default window. Expected records are
// queued at stimulus time and popped by per-instance monitors on handshakes.
module tb_response_signature_collector;

  logic CK = 1'b0;
  logic reset;

  logic        a_start, a_dout, a_ready, a_busy, a_valid;
  logic [15:0] a_sig;
  logic [1:0]  a_ones;

  logic        b_start, b_dout, b_ready, b_busy, b_valid;
  logic [15:0] b_sig;
  logic [9:0]  b_ones;

  typedef struct {
    logic [15:0] sig;
    int          ones;
  } rec_t;

  rec_t qa[$];
  rec_t qb[$];
  int   a_pops = 0, b_pops = 0;
  int   total = 0, passed = 0;

  always #5 CK = ~CK;

  response_signature_collector #(
    .SIG_W(16), .POLY(16'h1021), .SEED(16'h0000), .WINDOW(4), .CNT_W(2)
  ) dut_a (
    .CK(CK), .reset(reset), .start(a_start), .dut_out(a_dout),
    .busy(a_busy), .sig_valid(a_valid), .sig_ready(a_ready),
    .signature(a_sig), .ones_count(a_ones)
  );

  response_signature_collector #(
    .SIG_W(16), .POLY(16'h1021), .SEED(16'h0000), .WINDOW(1000), .CNT_W(10)
  ) dut_b (
    .CK(CK), .reset(reset), .start(b_start), .dut_out(b_dout),
    .busy(b_busy), .sig_valid(b_valid), .sig_ready(b_ready),
    .signature(b_sig), .ones_count(b_ones)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: actual %0h required %0h", name, act, exp);
    else passed++;
  endtask

  // Monitors: compare each accepted record against the head of its queue.
  always @(negedge CK) begin
    if (a_valid === 1'b1 && a_ready === 1'b1) begin
      if (qa.size() == 0) chk("a_unexpected_record", 32'd1, 32'd0);
      else begin
        rec_t r;
        r = qa.pop_front();
        a_pops++;
        chk("a_signature", {16'd0, a_sig}, {16'd0, r.sig});
        chk("a_ones_count", {30'd0, a_ones}, r.ones);
      end
    end
  end

  always @(negedge CK) begin
    if (b_valid === 1'b1 && b_ready === 1'b1) begin
      if (qb.size() == 0) chk("b_unexpected_record", 32'd1, 32'd0);
      else begin
        rec_t r;
        r = qb.pop_front();
        b_pops++;
        chk("b_signature", {16'd0, b_sig}, {16'd0, r.sig});
        chk("b_ones_count", {22'd0, b_ones}, r.ones);
      end
    end
  end

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  // One window on dut_a; bits[3] is the first sample. Returns one cycle after
  // the edge that takes the last sample (dut_a then sits in HOLD).
  task automatic run_a(input logic [3:0] bits, input logic [15:0] esig,
                       input int eones, input bit poke);
    rec_t r;
    r.sig = esig;
    r.ones = eones;
    qa.push_back(r);
    a_start = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      a_dout  = bits[3-i];
      a_start = poke && (i == 1);
      if (i == 3) begin
        chk("a_valid_before_last", {31'd0, a_valid}, 32'd0);
        chk("a_busy_capture", {31'd0, a_busy}, 32'd1);
      end
      step();
    end
    a_start = 1'b0;
    a_dout  = 1'b0;
    chk("a_valid_latency", {31'd0, a_valid}, 32'd1);
  endtask

  function automatic logic [15:0] ref_crc(input logic [15:0] s, input logic b);
    logic [15:0] sh;
    sh = {s[14:0], 1'b0};
    if (s[15] ^ b) sh = sh ^ 16'h1021;
    return sh;
  endfunction

  logic bv [1000];

  initial begin
    reset = 1'b1;
    a_start = 1'b0; a_dout = 1'b0; a_ready = 1'b1;
    b_start = 1'b0; b_dout = 1'b0; b_ready = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    chk("reset_busy", {31'd0, a_busy}, 32'd0);
    chk("reset_valid", {31'd0, a_valid}, 32'd0);
    chk("reset_sig", {16'd0, a_sig}, 32'd0);
    chk("reset_ones", {30'd0, a_ones}, 32'd0);
    step();

    // all-zero window, checks latency inside run_a
    run_a(4'b0000, 16'h0000, 0, 1'b0);
    step();
    // single leading one
    run_a(4'b1000, 16'h8108, 1, 1'b0);
    step();
    // saturating ones count: 4 ones in a 2-bit counter
    run_a(4'b1111, 16'hF1EF, 3, 1'b0);
    step();

    // back-pressure: record held stable for 10 cycles
    a_ready = 1'b0;
    run_a(4'b0001, 16'h1021, 1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_valid", {31'd0, a_valid}, 32'd1);
      chk("hold_sig", {16'd0, a_sig}, 32'h1021);
    end
    a_ready = 1'b1;
    step();
    chk("hs_valid_drop", {31'd0, a_valid}, 32'd0);
    chk("hs_busy_drop", {31'd0, a_busy}, 32'd0);
    chk("idle_sig_kept", {16'd0, a_sig}, 32'h1021);
    chk("idle_ones_kept", {30'd0, a_ones}, 32'd1);

    // start during capture and together with the handshake is ignored
    a_ready = 1'b0;
    run_a(4'b0110, 16'h60C6, 2, 1'b1);
    a_start = 1'b1;
    a_ready = 1'b1;
    step();
    a_start = 1'b0;
    chk("start_in_hold_dropped", {31'd0, a_busy}, 32'd0);
    step();
    chk("still_idle", {31'd0, a_busy}, 32'd0);

    // reset on the edge that would take sample 2
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    a_dout  = 1'b1;
    step();
    a_dout = 1'b0;
    reset  = 1'b1;
    step();
    chk("midrst_busy", {31'd0, a_busy}, 32'd0);
    chk("midrst_valid", {31'd0, a_valid}, 32'd0);
    chk("midrst_sig", {16'd0, a_sig}, 32'd0);
    reset = 1'b0;
    step();
    run_a(4'b1000, 16'h8108, 1, 1'b0);
    step();

    // long window with pseudo-random data against the reference CRC
    begin
      rec_t r;
      logic [15:0] m;
      int o;
      m = 16'h0000;
      o = 0;
      for (int i = 0; i < 1000; i++) begin
        bv[i] = 1'($urandom_range(1, 0));
        m = ref_crc(m, bv[i]);
        if (bv[i]) o++;
      end
      r.sig = m;
      r.ones = o;
      qb.push_back(r);
      b_start = 1'b1;
      step();
      b_start = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        b_dout = bv[i];
        step();
      end
      b_dout = 1'b0;
      chk("b_valid_after_window", {31'd0, b_valid}, 32'd1);
      step();
    end

    repeat (3) step();
    chk("a_queue_empty", qa.size(), 32'd0);
    chk("a_record_count", a_pops, 32'd6);
    chk("b_queue_empty", qb.size(), 32'd0);
    chk("b_record_count", b_pops, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
